// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation sequencer: left-to-right square-and-multiply over one external Montgomery multiplier.
// Optional MODEXP_SKIP_LZ_EN: skip leading zero exponent bits and dummy multiplies (data-dependent latency).
module mod_exp_ctrl #(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = 64
) (
    input  logic                 pclk,
    input  logic                 nreset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [WIDTH-1:0]     modulus,
    input  logic [WIDTH-1:0]     r2modm,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 mm_go,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH-1:0]     mm_p,
    input  logic                 mm_ready
);

    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [IW-1:0]    TOP_BIT = IW'(EXP_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_X,
        S_PRE_A,
        S_SQR,
        S_MUL,
        S_POST,
        S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic                 gap_q;
    logic [IW-1:0]        bit_q, bit_d;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [WIDTH-1:0]     r2_q;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     xbar_q, xbar_d;
    logic [WIDTH-1:0]     a_d, b_d;
    logic [WIDTH-1:0]     result_q;
    logic                 busy_q, done_q, err_q;
    logic                 mm_go_q;
    logic [WIDTH-1:0]     mm_a_q, mm_b_q, mm_m_q;

`ifdef MODEXP_SKIP_LZ_EN
    logic [IW-1:0] lz_idx;

    always_comb begin
        lz_idx = '0;
        for (int k = 0; k < EXP_WIDTH; k++) begin
            if (exp_q[k]) lz_idx = IW'(k);
        end
    end
`endif

    // Outcome of the op that completes this cycle: updated working values, next op, its operands.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        acc_d   = acc_q;
        xbar_d  = xbar_q;
        case (state_q)
            S_PRE_X: begin
                xbar_d  = mm_p;
                state_d = S_PRE_A;
            end
            S_PRE_A: begin
                acc_d = mm_p;
`ifdef MODEXP_SKIP_LZ_EN
                if (exp_q == '0) begin
                    state_d = S_POST;
                end else begin
                    // Top set bit: square of 1 times xbar is simply xbar.
                    acc_d = xbar_q;
                    if (lz_idx == '0) begin
                        state_d = S_POST;
                    end else begin
                        bit_d   = lz_idx - 1'b1;
                        state_d = S_SQR;
                    end
                end
`else
                bit_d   = TOP_BIT;
                state_d = S_SQR;
`endif
            end
            S_SQR: begin
                acc_d = mm_p;
`ifdef MODEXP_SKIP_LZ_EN
                if (exp_q[bit_q]) begin
                    state_d = S_MUL;
                end else if (bit_q == '0) begin
                    state_d = S_POST;
                end else begin
                    bit_d   = bit_q - 1'b1;
                    state_d = S_SQR;
                end
`else
                state_d = S_MUL;
`endif
            end
            S_MUL: begin
                // Product is always computed; it is kept only for a set bit.
                if (exp_q[bit_q]) acc_d = mm_p;
                if (bit_q == '0) begin
                    state_d = S_POST;
                end else begin
                    bit_d   = bit_q - 1'b1;
                    state_d = S_SQR;
                end
            end
            S_POST: begin
                state_d = S_FIN;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_comb begin
        a_d = mm_a_q;
        b_d = mm_b_q;
        case (state_d)
            S_PRE_A: begin
                a_d = ONE;
                b_d = r2_q;
            end
            S_SQR: begin
                a_d = acc_d;
                b_d = acc_d;
            end
            S_MUL: begin
                a_d = acc_d;
                b_d = xbar_d;
            end
            S_POST: begin
                a_d = acc_d;
                b_d = ONE;
            end
            default: begin
                a_d = mm_a_q;
                b_d = mm_b_q;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            gap_q    <= 1'b0;
            bit_q    <= '0;
            exp_q    <= '0;
            r2_q     <= '0;
            acc_q    <= '0;
            xbar_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mm_go_q  <= 1'b0;
            mm_a_q   <= '0;
            mm_b_q   <= '0;
            mm_m_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_q  <= 1'b0;
                        exp_q  <= exp;
                        r2_q   <= r2modm;
                        mm_m_q <= modulus;
                        if (!modulus[0]) begin
                            // Even modulus has no Montgomery form: fail without touching the multiplier.
                            result_q <= '0;
                            err_q    <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= S_FIN;
                        end else begin
                            busy_q  <= 1'b1;
                            gap_q   <= 1'b0;
                            mm_go_q <= 1'b1;
                            mm_a_q  <= base;
                            mm_b_q  <= r2modm;
                            state_q <= S_PRE_X;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    if (gap_q) begin
                        gap_q   <= 1'b0;
                        mm_go_q <= 1'b1;
                    end else if (mm_ready) begin
                        acc_q   <= acc_d;
                        xbar_q  <= xbar_d;
                        bit_q   <= bit_d;
                        mm_go_q <= 1'b0;
                        state_q <= state_d;
                        if (state_q == S_POST) begin
                            result_q <= mm_p;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            gap_q  <= 1'b1;
                            mm_a_q <= a_d;
                            mm_b_q <= b_d;
                        end
                    end
                end
            endcase
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign mm_go  = mm_go_q;
    assign mm_a   = mm_a_q;
    assign mm_b   = mm_b_q;
    assign mm_m   = mm_m_q;

endmodule
